// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves rs1/rs2 through EX/MEM and MEM/WB bypasses,
// interlocks on unresolved producers, and registers operands/control into ID/EX.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            IF_ID_valid,
    input  logic [RA-1:0]   IF_ID_rs1,
    input  logic [RA-1:0]   IF_ID_rs2,
    input  logic            IF_ID_uses_rs1,
    input  logic            IF_ID_uses_rs2,
    input  logic [XLEN-1:0] IF_ID_dout_rs1,
    input  logic [XLEN-1:0] IF_ID_dout_rs2,
    input  logic [RA-1:0]   IF_ID_rd,
    input  logic            IF_ID_regwrite,
    input  logic            IF_ID_memread,
    input  logic [RA-1:0]   EX_MEM_rd,
    input  logic            EX_MEM_regwrite,
    input  logic            EX_MEM_memread,
    input  logic [XLEN-1:0] EX_MEM_alures,
    input  logic [RA-1:0]   MEM_WB_rd,
    input  logic            MEM_WB_regwrite,
    input  logic [XLEN-1:0] WB_res,
    input  logic            flush,
    input  logic            stall_cnt_load_i,
    input  logic [31:0]     stall_cnt_load_val_i,
    output logic            stall_id,
    output logic            ID_EX_valid,
    output logic [XLEN-1:0] ID_EX_rs1_val,
    output logic [XLEN-1:0] ID_EX_rs2_val,
    output logic [RA-1:0]   ID_EX_rd,
    output logic            ID_EX_regwrite,
    output logic            ID_EX_memread,
    output logic [31:0]     stall_count
);

    logic            idExValid_q,    idExValid_d;
    logic [XLEN-1:0] idExRs1_q,      idExRs1_d;
    logic [XLEN-1:0] idExRs2_q,      idExRs2_d;
    logic [RA-1:0]   idExRd_q,       idExRd_d;
    logic            idExRegwrite_q, idExRegwrite_d;
    logic            idExMemread_q,  idExMemread_d;
    logic [31:0]     stallCount_q,   stallCount_d;
    logic [XLEN-1:0] rs1Sel, rs2Sel;
    logic            hzRs1, hzRs2;

    // Youngest producer wins; loads in MEM cannot forward, they interlock instead.
    function automatic logic [XLEN-1:0] selectOperand(input logic [RA-1:0] a,
                                                      input logic [XLEN-1:0] d);
        if (a == '0)
            return '0;
        if (EX_MEM_regwrite && !EX_MEM_memread && EX_MEM_rd == a)
            return EX_MEM_alures;
        if (MEM_WB_regwrite && MEM_WB_rd == a)
            return WB_res;
        return d;
    endfunction

    function automatic logic hazard(input logic [RA-1:0] a, input logic uses);
        return IF_ID_valid && uses && (a != '0) &&
               ((idExValid_q && idExRegwrite_q && idExRd_q == a) ||
                (EX_MEM_regwrite && EX_MEM_memread && EX_MEM_rd == a));
    endfunction

    always_comb begin
        rs1Sel = selectOperand(IF_ID_rs1, IF_ID_dout_rs1);
        rs2Sel = selectOperand(IF_ID_rs2, IF_ID_dout_rs2);
        hzRs1  = hazard(IF_ID_rs1, IF_ID_uses_rs1);
        hzRs2  = hazard(IF_ID_rs2, IF_ID_uses_rs2);
    end

    assign stall_id = (hzRs1 || hzRs2) && !flush;

    // Flush and stall both leave a bubble; the held IF/ID instruction retries next cycle.
    always_comb begin
        idExValid_d    = 1'b0;
        idExRs1_d      = '0;
        idExRs2_d      = '0;
        idExRd_d       = '0;
        idExRegwrite_d = 1'b0;
        idExMemread_d  = 1'b0;
        if (!(flush || stall_id)) begin
            idExValid_d    = IF_ID_valid;
            idExRs1_d      = rs1Sel;
            idExRs2_d      = rs2Sel;
            idExRd_d       = IF_ID_rd;
            idExRegwrite_d = IF_ID_regwrite && IF_ID_valid;
            idExMemread_d  = IF_ID_memread && IF_ID_valid;
        end
        stallCount_d = stallCount_q;
        if (stall_cnt_load_i)
            stallCount_d = stall_cnt_load_val_i;
        else if (stall_id && stallCount_q != 32'hFFFF_FFFF)
            stallCount_d = stallCount_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            idExValid_q    <= 1'b0;
            idExRs1_q      <= '0;
            idExRs2_q      <= '0;
            idExRd_q       <= '0;
            idExRegwrite_q <= 1'b0;
            idExMemread_q  <= 1'b0;
            stallCount_q   <= '0;
        end else begin
            idExValid_q    <= idExValid_d;
            idExRs1_q      <= idExRs1_d;
            idExRs2_q      <= idExRs2_d;
            idExRd_q       <= idExRd_d;
            idExRegwrite_q <= idExRegwrite_d;
            idExMemread_q  <= idExMemread_d;
            stallCount_q   <= stallCount_d;
        end
    end

    assign ID_EX_valid    = idExValid_q;
    assign ID_EX_rs1_val  = idExRs1_q;
    assign ID_EX_rs2_val  = idExRs2_q;
    assign ID_EX_rd       = idExRd_q;
    assign ID_EX_regwrite = idExRegwrite_q;
    assign ID_EX_memread  = idExMemread_q;
    assign stall_count    = stallCount_q;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute operand stage of the Mini-RISC-V pipeline. It sits directly downstream of the register file. It takes the asynchronous rs1/rs2 read data for the instruction in IF/ID and resolves RAW hazards by bypassing from EX/MEM and MEM/WB, or by interlocking. It then latches the resolved operands and control into the ID/EX pipeline register. It also generates the decode stall, inserts bubbles on stall and flush, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- XLEN, 32, data width
- RA, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- IF_ID_valid  in  1  decode slot holds a real instruction
- IF_ID_rs1, IF_ID_rs2  in  RA  source register addresses
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1  instruction actually reads rs1 / rs2
- IF_ID_dout_rs1, IF_ID_dout_rs2  in  XLEN  register file read data; x0 already reads 0
- IF_ID_rd  in  RA  destination register
- IF_ID_regwrite, IF_ID_memread  in  1  decoded writeback / load controls
- EX_MEM_rd  in  RA  destination register of the instruction in MEM
- EX_MEM_regwrite, EX_MEM_memread  in  1  controls of the instruction in MEM
- EX_MEM_alures  in  XLEN  ALU result of the instruction in MEM
- MEM_WB_rd  in  RA  writeback destination
- MEM_WB_regwrite  in  1  writeback enable
- WB_res  in  XLEN  writeback data
- flush  in  1  squash the decode instruction (taken branch/jump)
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- ID_EX_valid  out  1  registered instruction valid
- ID_EX_rs1_val, ID_EX_rs2_val  out  XLEN  registered resolved operands
- ID_EX_rd  out  RA  registered destination
- ID_EX_regwrite, ID_EX_memread  out  1  registered controls
- stall_count  out  32  number of stall cycles since reset, saturating

## Operation
Operand select, evaluated independently for rs1 and rs2 (address a, regfile data d):
- a == 0: value 0; no forwarding, never a hazard.
- EX_MEM_regwrite && EX_MEM_rd == a && !EX_MEM_memread: value EX_MEM_alures.
- Else if MEM_WB_regwrite && MEM_WB_rd == a: value WB_res. This covers the same-cycle write/read hole in the register file.
- Otherwise: value d.
- EX_MEM has priority over MEM_WB (youngest producer wins).

Hazard terms (each qualified by IF_ID_valid and the matching uses flag, with a != 0):
- hz_ex: ID_EX_valid && ID_EX_regwrite && ID_EX_rd == a. The producer is in EX and its result is not yet available.
- hz_ld: EX_MEM_regwrite && EX_MEM_memread && EX_MEM_rd == a. The load data is not available until WB.
- stall_id = (hz_ex || hz_ld for rs1 or rs2) && !flush.

ID/EX register update on each rising edge, in priority order:
- Rst: all ID_EX_* outputs 0; stall_count 0.
- flush: bubble (valid, regwrite, memread = 0; rd = 0; operands = 0).
- stall_id: bubble as above. IF/ID is held upstream, so the instruction re-evaluates next cycle.
- Otherwise: valid, rd, regwrite and memread are copied from IF_ID_*. The operand values come from the select above. If IF_ID_valid = 0, regwrite and memread are forced to 0.

Performance counter:
- stall_count increments by 1 on every edge where stall_id = 1 and Rst = 0.
- It saturates at 32'hFFFF_FFFF.

## Timing
- Forwarding and stall are combinational from current-cycle inputs. stall_id is valid in the same cycle.
- Operand latency: 1 clock, from IF/ID inputs to ID_EX_* outputs.
- Interlock lengths with back-to-back dependents:
  - ALU producer: 1 stall cycle, after which the value is bypassed from EX_MEM.
  - Load producer: 2 stall cycles, after which the value is bypassed from WB_res.
- Simultaneous flush and hazard: flush wins, stall_id = 0, a bubble is inserted, and the counter does not increment.
- Reset mid-stall: on the next edge all state is cleared. stall_id then follows the current-cycle inputs, and the ID/EX terms are 0 after reset.
- Both sources equal to the same register: both operands get the same forwarded value, and a single stall covers both.
- Writes to x0 by a producer (rd = 0) never forward and never stall.

## Test plan
- Reset: assert Rst for 2 cycles with garbage inputs -> all ID_EX_* = 0, stall_count = 0, stall_id follows the inputs.
- ALU-use chain: "addi x5,x0,7" then "add x6,x5,x5" -> 1 stall cycle, stall_count = 1. Next cycle ID_EX_rs1_val = ID_EX_rs2_val = 7, sourced from EX_MEM_alures.
- Load-use: load x7 (memory returns 0x1234_5678) followed by a reader of x7 -> stall_id high for 2 cycles. Then ID_EX_rs1_val = 0x1234_5678 from WB_res, stall_count = 2.
- Priority and WB bypass:
  - EX_MEM writes x3 = 0xAAAA and MEM_WB writes x3 = 0xBBBB -> operand 0xAAAA.
  - MEM_WB only, with regfile data stale at 0 -> operand 0xBBBB.
- x0 and flush:
  - Producer with rd = 0 and a consumer of x0 -> no stall, operand 0.
  - flush asserted during an active load-use hazard -> stall_id = 0, next ID_EX_valid = 0, counter unchanged.
- Counter saturation: preload stall_count to 32'hFFFF_FFFE through the test hook and force 3 stall cycles -> stall_count = 32'hFFFF_FFFF.
